// File: rtl/snn_config_sequencer_if.sv
// rtl/snn_config_sequencer_if.sv - command/response bus between the sequencer and the SNN network
interface snn_config_sequencer_if #(
    parameter int ADDR_WIDTH  = 3,
    parameter int CMD_WIDTH   = 3,
    parameter int FLOAT_WIDTH = 8
);
    logic                   net_rst;
    logic [ADDR_WIDTH-1:0]  net_addr;
    logic [CMD_WIDTH-1:0]   net_cmd;
    logic [FLOAT_WIDTH-1:0] net_cmd_arg;
    logic                   net_in1;
    logic                   net_in2;
    logic                   net_out;
    logic [31:0]            net_out_time;

    modport master (
        output net_rst, net_addr, net_cmd, net_cmd_arg, net_in1, net_in2,
        input  net_out, net_out_time
    );

    modport slave (
        input  net_rst, net_addr, net_cmd, net_cmd_arg, net_in1, net_in2,
        output net_out, net_out_time
    );
endinterface

// File: rtl/snn_config_sequencer.sv
// rtl/snn_config_sequencer.sv - replays a config table onto the SNN bus, runs one job, captures the result
module snn_config_sequencer #(
    parameter int INT_WIDTH   = 4,
    parameter int FLOAT_WIDTH = 2*INT_WIDTH,
    parameter int CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH  = 3,
    parameter int DEPTH       = 32,
    parameter int PTR_WIDTH   = $clog2(DEPTH)+1,
    parameter int RUN_CYCLES  = 35
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      tbl_we,
    input  logic [PTR_WIDTH-2:0]                      tbl_waddr,
    input  logic [ADDR_WIDTH+CMD_WIDTH+FLOAT_WIDTH-1:0] tbl_wdata,
    input  logic [PTR_WIDTH-1:0]                      tbl_len,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic                                      in1,
    input  logic                                      in2,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      result,
    output logic [31:0]                               result_time,
    snn_config_sequencer_if.master                    net
);
    localparam int ENTRY_W = ADDR_WIDTH + CMD_WIDTH + FLOAT_WIDTH;
    localparam int IDX_W   = PTR_WIDTH - 1;
    localparam int CNT_W   = $clog2(RUN_CYCLES + 1);

    localparam logic [CMD_WIDTH-1:0] CMD_CLEAR = CMD_WIDTH'((1 << CMD_WIDTH) - 3);
    localparam logic [ENTRY_W-1:0]   BUS_IDLE  = {{ADDR_WIDTH{1'b1}}, {(CMD_WIDTH+FLOAT_WIDTH){1'b0}}};
    localparam logic [ENTRY_W-1:0]   BUS_CLEAR = {{ADDR_WIDTH{1'b1}}, CMD_CLEAR, {FLOAT_WIDTH{1'b0}}};
    localparam logic [PTR_WIDTH-1:0] LEN_MAX   = PTR_WIDTH'(DEPTH);
    localparam logic [CNT_W-1:0]     RUN_LAST  = CNT_W'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_NETRST,
        S_LOAD,
        S_GAP,
        S_CLEAR,
        S_RUN
    } state_t;

    state_t               state;
    logic [ENTRY_W-1:0]   tbl [DEPTH];
    logic [ENTRY_W-1:0]   rd_entry;
    logic [ENTRY_W-1:0]   bus_q;
    logic                 net_rst_q;
    logic                 in1_q;
    logic                 in2_q;
    logic [PTR_WIDTH-1:0] len_q;
    logic [PTR_WIDTH-1:0] idx;
    logic [CNT_W-1:0]     run_cnt;

    // Table only accepts writes between jobs so a running replay never sees a torn program.
    always_ff @(posedge clk) begin
        if (tbl_we && state == S_IDLE) begin
            tbl[tbl_waddr] <= tbl_wdata;
        end
    end

    assign rd_entry = tbl[idx[IDX_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= 1'b0;
            result_time <= '0;
            net_rst_q   <= 1'b1;
            bus_q       <= BUS_IDLE;
            in1_q       <= 1'b0;
            in2_q       <= 1'b0;
            len_q       <= '0;
            idx         <= '0;
            run_cnt     <= '0;
        end else begin
            done <= 1'b0;
            if (abort && state != S_IDLE) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                net_rst_q <= 1'b1;
                bus_q     <= BUS_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state     <= S_NETRST;
                            busy      <= 1'b1;
                            net_rst_q <= 1'b1;
                            bus_q     <= BUS_IDLE;
                            in1_q     <= in1;
                            in2_q     <= in2;
                            len_q     <= (tbl_len > LEN_MAX) ? LEN_MAX : tbl_len;
                            idx       <= '0;
                        end
                    end
                    S_NETRST: begin
                        net_rst_q <= 1'b0;
                        if (len_q == '0) begin
                            state <= S_CLEAR;
                            bus_q <= BUS_CLEAR;
                        end else begin
                            state <= S_LOAD;
                            bus_q <= rd_entry;
                        end
                    end
                    S_LOAD: begin
                        state <= S_GAP;
                        bus_q <= BUS_IDLE;
                        idx   <= idx + PTR_WIDTH'(1);
                    end
                    // idx already points at the next entry; equality with len means the table is exhausted.
                    S_GAP: begin
                        if (idx == len_q) begin
                            state <= S_CLEAR;
                            bus_q <= BUS_CLEAR;
                        end else begin
                            state <= S_LOAD;
                            bus_q <= rd_entry;
                        end
                    end
                    S_CLEAR: begin
                        state   <= S_RUN;
                        bus_q   <= BUS_IDLE;
                        run_cnt <= RUN_LAST;
                    end
                    S_RUN: begin
                        if (run_cnt == '0) begin
                            state       <= S_IDLE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            result      <= net.net_out;
                            result_time <= net.net_out_time;
                            net_rst_q   <= 1'b1;
                        end else begin
                            run_cnt <= run_cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign net.net_rst     = net_rst_q;
    assign net.net_addr    = bus_q[ENTRY_W-1 -: ADDR_WIDTH];
    assign net.net_cmd     = bus_q[FLOAT_WIDTH +: CMD_WIDTH];
    assign net.net_cmd_arg = bus_q[FLOAT_WIDTH-1:0];
    assign net.net_in1     = in1_q;
    assign net.net_in2     = in2_q;
endmodule

// File: tb/tb_snn_config_sequencer.sv
// tb/tb_snn_config_sequencer.sv - self-checking bench for snn_config_sequencer
module tb_snn_config_sequencer;
    localparam int DEPTH = 32;
    localparam int RUN   = 35;
    localparam logic [13:0] BUS_IDLE  = {3'b111, 3'd0, 8'd0};
    localparam logic [13:0] BUS_CLEAR = {3'b111, 3'd5, 8'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tbl_we = 1'b0;
    logic [4:0]  tbl_waddr = '0;
    logic [13:0] tbl_wdata = '0;
    logic [5:0]  tbl_len = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in1 = 1'b0;
    logic        in2 = 1'b0;
    logic        busy;
    logic        done;
    logic        result;
    logic [31:0] result_time;

    snn_config_sequencer_if #(.ADDR_WIDTH(3), .CMD_WIDTH(3), .FLOAT_WIDTH(8)) nif ();

    snn_config_sequencer #(
        .INT_WIDTH(4), .FLOAT_WIDTH(8), .CMD_WIDTH(3), .ADDR_WIDTH(3),
        .DEPTH(DEPTH), .PTR_WIDTH(6), .RUN_CYCLES(RUN)
    ) dut (
        .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
        .tbl_wdata(tbl_wdata), .tbl_len(tbl_len), .start(start), .abort(abort),
        .in1(in1), .in2(in2), .busy(busy), .done(done), .result(result),
        .result_time(result_time), .net(nif)
    );

    always #5 clk = ~clk;

    // Toy network: XOR of its inputs, out_time counts cycles since reset release.
    int unsigned net_t = 0;
    always @(posedge clk) net_t <= nif.net_rst ? 0 : net_t + 1;
    assign nif.net_out      = nif.net_in1 ^ nif.net_in2;
    assign nif.net_out_time = net_t;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [13:0] ent; } bus_ev_t;
    bus_ev_t bus_log[$];
    int      done_log[$];

    always @(negedge clk) begin
        if (rst) begin
            if (!nif.net_rst && {nif.net_addr, nif.net_cmd, nif.net_cmd_arg} != BUS_IDLE)
                bus_log.push_back('{cyc: cyc + 1, ent: {nif.net_addr, nif.net_cmd, nif.net_cmd_arg}});
            if (done) done_log.push_back(cyc + 1);
        end
    end

    logic [13:0] model_tbl [DEPTH];
    logic        exp_result = 1'b0;
    int          exp_time = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] rand_entry();
        return {3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)), 8'($urandom)};
    endfunction

    task automatic write_entry(input int idx, input logic [13:0] e);
        @(negedge clk);
        tbl_we = 1'b1; tbl_waddr = 5'(idx); tbl_wdata = e;
        @(posedge clk); #1;
        tbl_we = 1'b0;
        model_tbl[idx] = e;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_rtime"}, result_time, 0);
        check({tag, "_net_rst"}, nif.net_rst, 1);
        check({tag, "_bus"}, {nif.net_addr, nif.net_cmd, nif.net_cmd_arg}, BUS_IDLE);
        check({tag, "_net_in"}, {nif.net_in1, nif.net_in2}, 0);
    endtask

    task automatic wait_cycle(input int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc + 1 < c && n < 500);
    endtask

    task automatic start_job(input int len, input bit i1, input bit i2, input bit wr, output int k);
        logic [13:0] e;
        @(negedge clk);
        start = 1'b1; in1 = i1; in2 = i2; tbl_len = 6'(len);
        if (wr) begin
            e = rand_entry();
            tbl_we = 1'b1; tbl_waddr = 5'd0; tbl_wdata = e;
            model_tbl[0] = e;
        end
        @(posedge clk); #1;
        k = cyc;
        start = 1'b0; tbl_we = 1'b0; in1 = ~i1; in2 = ~i2;
        bus_log.delete();
        done_log.delete();
    endtask

    // Expected job: entries 0..L-1 on even offsets from 2, CLEAR at 2+2L, done at 3+2L+RUN.
    task automatic finish_job(input int k, input int len, input bit i1, input bit i2);
        int L;
        int n;
        L = (len > DEPTH) ? DEPTH : len;
        n = 0;
        while (done_log.size() == 0 && n < 2 * DEPTH + RUN + 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("done_seen", done_log.size(), 1);
        check("bus_count", bus_log.size(), L + 1);
        for (int i = 0; i < L && i < bus_log.size(); i++) begin
            check("load_cyc", bus_log[i].cyc - k, 2 + 2 * i);
            check("load_ent", bus_log[i].ent, model_tbl[i]);
        end
        if (bus_log.size() == L + 1) begin
            check("clear_cyc", bus_log[L].cyc - k, 2 + 2 * L);
            check("clear_ent", bus_log[L].ent, BUS_CLEAR);
        end
        if (done_log.size() > 0) check("done_cyc", done_log[0] - k, 3 + 2 * L + RUN);
        exp_result = i1 ^ i2;
        exp_time   = 2 * L + RUN;
        check("result", result, exp_result);
        check("result_time", result_time, exp_time);
        check("idle_busy", busy, 0);
        check("idle_net_rst", nif.net_rst, 1);
    endtask

    typedef struct {
        int len; bit i1; bit i2; bit wr;
        int clear_off; int done_off; bit res;
    } vec_t;

    initial begin
        vec_t vecs[6];
        bit   pats[4][2];
        int   k;
        int   len;
        bit   a, b;
        logic [13:0] e;
        logic [13:0] old3;

        vecs[0] = '{16, 0, 1, 0, 34,  70, 1};
        vecs[1] = '{ 0, 0, 0, 0,  2,  38, 0};
        vecs[2] = '{ 1, 1, 0, 1,  4,  40, 1};
        vecs[3] = '{32, 1, 1, 0, 66, 102, 0};
        vecs[4] = '{40, 0, 1, 0, 66, 102, 1};
        vecs[5] = '{16, 1, 1, 1, 34,  70, 0};
        pats[0] = '{0, 0}; pats[1] = '{0, 1}; pats[2] = '{1, 0}; pats[3] = '{1, 1};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        for (int i = 0; i < DEPTH; i++) write_entry(i, rand_entry());
        for (int i = 0; i < 16; i++) begin
            if (i < 12)       e = {3'(i % 6), 3'd1, 8'((i * 5 + 3) % 16)};
            else if (i == 12) e = {3'd6, 3'd4, 8'd15};
            else              e = {3'(i - 13), 3'd3, (i == 13) ? 8'd12 : 8'd2};
            write_entry(i, e);
        end

        for (int v = 0; v < 6; v++) begin
            start_job(vecs[v].len, vecs[v].i1, vecs[v].i2, vecs[v].wr, k);
            finish_job(k, vecs[v].len, vecs[v].i1, vecs[v].i2);
            if (bus_log.size() > 0) check("vec_clear_off", bus_log[bus_log.size() - 1].cyc - k, vecs[v].clear_off);
            if (done_log.size() > 0) check("vec_done_off", done_log[0] - k, vecs[v].done_off);
            check("vec_result", result, vecs[v].res);
        end

        // Back-to-back jobs with start held high; the next job launches in each done cycle.
        @(negedge clk);
        start = 1'b1; tbl_len = 6'd16; in1 = pats[0][0]; in2 = pats[0][1];
        @(posedge clk); #1;
        k = cyc;
        bus_log.delete();
        done_log.delete();
        for (int j = 0; j < 4; j++) begin
            wait_cycle(k + 70 * (j + 1));
            check("b2b_done", done, 1);
            check("b2b_busy", busy, 0);
            check("b2b_result", result, pats[j][0] ^ pats[j][1]);
            check("b2b_rtime", result_time, 2 * 16 + RUN);
            if (j < 3) begin
                in1 = pats[j + 1][0]; in2 = pats[j + 1][1];
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check("b2b_done_count", done_log.size(), 4);
        for (int j = 0; j < 4 && j < done_log.size(); j++) check("b2b_done_cyc", done_log[j] - k, 70 * (j + 1));
        check("b2b_bus_count", bus_log.size(), 4 * 17);

        // start and a table write during LOAD must both be ignored.
        old3 = model_tbl[3];
        start_job(16, 0, 1, 0, k);
        wait_cycle(k + 6);
        start = 1'b1; tbl_we = 1'b1; tbl_waddr = 5'd3; tbl_wdata = ~old3;
        @(negedge clk);
        start = 1'b0; tbl_we = 1'b0;
        finish_job(k, 16, 0, 1);
        start_job(16, 1, 0, 0, k);
        finish_job(k, 16, 1, 0);
        check("frozen_entry3", bus_log.size() > 3 ? bus_log[3].ent : 14'h0, old3);

        // Abort mid-job: back to idle next cycle, no done, result preserved.
        start_job(16, 1, 1, 0, k);
        wait_cycle(k + 10);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_net_rst", nif.net_rst, 1);
        check("abort_bus", {nif.net_addr, nif.net_cmd, nif.net_cmd_arg}, BUS_IDLE);
        check("abort_done", done, 0);
        repeat (90) @(negedge clk);
        check("abort_no_done", done_log.size(), 0);
        check("abort_result_kept", result, exp_result);
        check("abort_rtime_kept", result_time, exp_time);
        start_job(16, 0, 1, 0, k);
        finish_job(k, 16, 0, 1);

        // Asynchronous reset in the middle of RUN.
        start_job(0, 1, 0, 0, k);
        wait_cycle(k + 20);
        #2 rst = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;
        start_job(16, 0, 1, 0, k);
        finish_job(k, 16, 0, 1);

        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 3; w++) write_entry($urandom_range(0, DEPTH - 1), rand_entry());
            len = $urandom_range(0, DEPTH + 4);
            a = 1'($urandom);
            b = 1'($urandom);
            start_job(len, a, b, 1'($urandom), k);
            finish_job(k, len, a, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
